wb_mtimer: RTL and testbench



---
 rtl/wb_mtimer_pkg.sv | 39 +++
 rtl/wb_mtimer_if.sv | 29 ++
 rtl/wb_mtimer_prescaler.sv | 31 +++
 rtl/wb_mtimer.sv | 125 ++++++++++++
 tb/tb_wb_mtimer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_mtimer_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_mtimer_pkg
// Desc   : Register offsets, CTRL bit indices and helpers for wb_mtimer.
// Rev    : 1.0  initial release
// ============================================================================
package wb_mtimer_pkg;

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    // Encoded so that bit 0 is the ack flop and bit 1 is the err flop.
    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_ACK  = 2'b01,
        RESP_ERR  = 2'b10
    } resp_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  sel
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mtimer_if.sv
`default_nettype none
// ============================================================================
// Module : wb_mtimer_if
// Desc   : Wishbone B4 classic bus bundle plus timer interrupt line.
// Rev    : 1.0  initial release
// ============================================================================
interface wb_mtimer_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o, irq_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_mtimer_prescaler.sv
`default_nettype none
// ============================================================================
// Module : mtimer_prescaler
// Desc   : Divides the clock by prescale+1 and emits a one-cycle mtime tick.
// Rev    : 1.0  initial release
// ============================================================================
module mtimer_prescaler (
    input  wire        clk,
    input  wire        rst,
    input  wire        en_i,
    input  wire [31:0] prescale_i,
    input  wire        clr_i,
    output logic       tick_o
);
    logic [31:0] pre_cnt_q;
    logic        w_hit;

    assign w_hit  = (pre_cnt_q == prescale_i);
    assign tick_o = en_i & w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= 32'd0;
        end else if (clr_i) begin
            pre_cnt_q <= 32'd0;
        end else if (en_i) begin
            pre_cnt_q <= w_hit ? 32'd0 : pre_cnt_q + 32'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/wb_mtimer.sv
`default_nettype none
// ============================================================================
// Module : wb_mtimer
// Desc   : Wishbone B4 classic RISC-V machine timer with prescaler and IRQ.
// Rev    : 1.0  initial release
// ============================================================================
module wb_mtimer
    import wb_mtimer_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RESET = 32'd0,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  wire        wb_clk_i,
    input  wire        wb_rst_i,
    wb_mtimer_if.slave wb
);
    resp_e       resp_q;
    logic [31:0] dat_q;
    logic        irq_q;
    logic [63:0] mtime_q;
    logic [63:0] mtime_d;
    logic [63:0] mtimecmp_q;
    logic        en_q;
    logic        ie_q;
    logic [31:0] prescale_q;
    logic [31:0] hi_shadow_q;

    logic        w_req;
    logic        w_mapped;
    logic        w_wr;
    logic        w_tick;
    logic [2:0]  w_off;
    logic [31:0] w_cur;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic        w_unused;

    assign w_off    = wb.wb_adr_i[4:2];
    assign w_mapped = (w_off <= REG_PRESCALE);
    assign w_req    = wb.wb_cyc_i & wb.wb_stb_i & (resp_q == RESP_NONE);
    assign w_wr     = w_req & wb.wb_we_i & w_mapped;
    assign w_unused = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

    mtimer_prescaler u_prescaler (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .en_i       (en_q),
        .prescale_i (prescale_q),
        .clr_i      (w_wr && (w_off == REG_PRESCALE)),
        .tick_o     (w_tick)
    );

    // Raw register contents at the addressed offset; byte merges start here.
    always_comb begin
        w_cur = 32'd0;
        case (w_off)
            REG_MTIME_LO:    w_cur = mtime_q[31:0];
            REG_MTIME_HI:    w_cur = mtime_q[63:32];
            REG_MTIMECMP_LO: w_cur = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: w_cur = mtimecmp_q[63:32];
            REG_CTRL:        w_cur = {30'd0, ie_q, en_q};
            REG_PRESCALE:    w_cur = prescale_q;
            default:         w_cur = 32'd0;
        endcase
    end

    assign w_rdata  = (w_off == REG_MTIME_HI) ? hi_shadow_q : w_cur;
    assign w_merged = byte_merge(w_cur, wb.wb_dat_i, wb.wb_sel_i);

    // A bus write to either half overrides the tick; the other half keeps its old value.
    always_comb begin
        mtime_d = mtime_q;
        if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (w_wr && (w_off == REG_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], w_merged};
        end else if (w_wr && (w_off == REG_MTIME_HI)) begin
            mtime_d = {w_merged, mtime_q[31:0]};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            resp_q      <= RESP_NONE;
            dat_q       <= 32'd0;
            irq_q       <= 1'b0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RESET;
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            prescale_q  <= PRESCALE_RESET;
            hi_shadow_q <= 32'd0;
        end else begin
            resp_q  <= RESP_NONE;
            if (w_req) begin
                resp_q <= w_mapped ? RESP_ACK : RESP_ERR;
                dat_q  <= w_rdata;
            end
            irq_q   <= ie_q & (mtime_q >= mtimecmp_q);
            mtime_q <= mtime_d;
            if (w_req && !wb.wb_we_i && (w_off == REG_MTIME_LO)) begin
                hi_shadow_q <= mtime_q[63:32];
            end
            if (w_wr) begin
                case (w_off)
                    REG_MTIMECMP_LO: mtimecmp_q[31:0]  <= w_merged;
                    REG_MTIMECMP_HI: mtimecmp_q[63:32] <= w_merged;
                    REG_CTRL: begin
                        en_q <= w_merged[CTRL_EN];
                        ie_q <= w_merged[CTRL_IE];
                    end
                    REG_PRESCALE:    prescale_q <= w_merged;
                    default: ;
                endcase
            end
        end
    end

    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = resp_q[0];
    assign wb.wb_err_o = resp_q[1];
    assign wb.irq_o    = irq_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_mtimer.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_mtimer
// Desc   : Scoreboard bench for wb_mtimer against a behavioural timer model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_mtimer;
    typedef struct {
        bit          err;
        bit          chk;
        logic [31:0] dat;
        int unsigned due;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    wb_mtimer_if bus ();

    wb_mtimer #(
        .PRESCALE_RESET (32'd0),
        .MTIMECMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb       (bus)
    );

    int unsigned checks   = 0;
    int unsigned errors   = 0;
    int unsigned edge_cnt = 0;
    bit          mon_on   = 0;
    exp_t        exp_q[$];
    string       reg_name[8] = '{"MTIME_LO", "MTIME_HI", "MTIMECMP_LO", "MTIMECMP_HI",
                                 "CTRL", "PRESCALE", "UNMAP6", "UNMAP7"};

    // Model state: what the timer should hold after each clock edge.
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_pre, m_shadow;
    longint      m_phase;
    bit          m_en, m_ie, m_busy, m_irq;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lane_mix(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic model_edge();
        logic [63:0] t_old;
        logic [31:0] rd, nv;
        logic [2:0]  off;
        bit          req, tick;
        exp_t        e;
        edge_cnt++;
        if (rst) begin
            m_mtime = 64'd0; m_cmp = '1; m_pre = 32'd0; m_shadow = 32'd0; m_phase = 0;
            m_en = 0; m_ie = 0; m_busy = 0; m_irq = 0;
            return;
        end
        req    = bus.wb_cyc_i && bus.wb_stb_i && !m_busy;
        m_busy = req;
        off    = bus.wb_adr_i[4:2];
        t_old  = m_mtime;
        m_irq  = m_ie && (m_mtime >= m_cmp);
        tick   = m_en && (m_phase == longint'(m_pre));
        if (m_en) m_phase = tick ? 0 : m_phase + 1;
        if (tick) m_mtime = m_mtime + 64'd1;
        if (req) begin
            rd = 32'd0;
            case (off)
                3'd0: begin rd = t_old[31:0]; if (!bus.wb_we_i) m_shadow = t_old[63:32]; end
                3'd1: rd = m_shadow;
                3'd2: rd = m_cmp[31:0];
                3'd3: rd = m_cmp[63:32];
                3'd4: rd = {30'd0, m_ie, m_en};
                3'd5: rd = m_pre;
                default: rd = 32'd0;
            endcase
            if (bus.wb_we_i) begin
                case (off)
                    3'd0: m_mtime = {t_old[63:32], lane_mix(t_old[31:0], bus.wb_dat_i, bus.wb_sel_i)};
                    3'd1: m_mtime = {lane_mix(t_old[63:32], bus.wb_dat_i, bus.wb_sel_i), t_old[31:0]};
                    3'd2: m_cmp[31:0]  = lane_mix(m_cmp[31:0], bus.wb_dat_i, bus.wb_sel_i);
                    3'd3: m_cmp[63:32] = lane_mix(m_cmp[63:32], bus.wb_dat_i, bus.wb_sel_i);
                    3'd4: begin
                        nv   = lane_mix({30'd0, m_ie, m_en}, bus.wb_dat_i, bus.wb_sel_i);
                        m_en = nv[0];
                        m_ie = nv[1];
                    end
                    3'd5: begin
                        m_pre   = lane_mix(m_pre, bus.wb_dat_i, bus.wb_sel_i);
                        m_phase = 0;
                    end
                    default: ;
                endcase
            end
            e.err = (off >= 3'd6);
            e.chk = !bus.wb_we_i;
            e.dat = rd;
            e.due = edge_cnt;
            e.tag = reg_name[off];
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    task automatic monitor();
        exp_t e;
        if (!mon_on) return;
        chk("irq_o", {63'd0, bus.irq_o}, {63'd0, m_irq});
        if (bus.wb_ack_o || bus.wb_err_o) begin
            chk("ack_err_exclusive", {63'd0, bus.wb_ack_o & bus.wb_err_o}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_response", {63'd0, bus.wb_ack_o | bus.wb_err_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_latency"}, 64'(edge_cnt), 64'(e.due));
                chk({e.tag, "_err"}, {63'd0, bus.wb_err_o}, {63'd0, e.err});
                chk({e.tag, "_ack"}, {63'd0, bus.wb_ack_o}, {63'd0, !e.err});
                if (e.chk) chk({e.tag, "_rdata"}, {32'd0, bus.wb_dat_o}, {32'd0, e.dat});
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
            e = exp_q.pop_front();
            chk({e.tag, "_missing_response"}, 64'd0, 64'd1);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor();
        end
    end

    task automatic drive(input logic [2:0] off, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat);
        bus.wb_adr_i = ($urandom() & 32'hFFFF_FFE3) | {27'd0, off, 2'b00};
        bus.wb_we_i  = we;
        bus.wb_sel_i = sel;
        bus.wb_dat_i = dat;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
    endtask

    task automatic release_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    // One request cycle; cyc drops while the response is still pending.
    task automatic xfer(input logic [2:0] off, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat);
        @(negedge clk);
        drive(off, we, sel, dat);
        @(negedge clk);
        release_bus();
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] dat);
        xfer(off, 1'b1, 4'hF, dat);
    endtask

    task automatic rd(input logic [2:0] off);
        xfer(off, 1'b0, 4'hF, $urandom());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [2:0] off, input int n);
        @(negedge clk);
        drive(off, 1'b0, 4'hF, 32'd0);
        repeat (n) @(negedge clk);
        release_bus();
    endtask

    initial begin
        logic [2:0]  off;
        logic [31:0] dat;
        rst = 1'b1;
        bus.wb_adr_i = 32'd0;
        bus.wb_dat_i = 32'd0;
        bus.wb_sel_i = 4'd0;
        release_bus();
        repeat (3) @(negedge clk);
        mon_on = 1;
        rst    = 1'b0;

        for (int i = 0; i < 6; i++) rd(3'(i));

        wr(3'd5, 32'd3);
        wr(3'd4, 32'd1);
        idle(40);
        rd(3'd0);
        wr(3'd4, 32'd0);
        idle(10);
        rd(3'd0);
        rd(3'd0);

        wr(3'd1, 32'd0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd(3'd0);
            rd(3'd1);
        end

        wr(3'd4, 32'd0);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'd100);
        wr(3'd4, 32'd3);
        idle(110);
        wr(3'd2, 32'hFFFF_FFFF);
        idle(3);
        wr(3'd4, 32'd1);
        wr(3'd2, 32'd0);
        idle(5);

        wr(3'd2, 32'hFFFF_FFFF);
        xfer(3'd2, 1'b1, 4'b0010, 32'hAABB_CCDD);
        rd(3'd2);

        rd(3'd6);
        xfer(3'd6, 1'b1, 4'hF, 32'h1234_5678);
        xfer(3'd7, 1'b1, 4'hF, 32'hDEAD_BEEF);
        for (int i = 0; i < 6; i++) rd(3'(i));

        wr(3'd0, 32'd5);
        rd(3'd0);
        hold(3'd4, 7);

        @(negedge clk);
        drive(3'd3, 1'b1, 4'hF, 32'h0BAD_0BAD);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_transfer_ack", {63'd0, bus.wb_ack_o | bus.wb_err_o}, 64'd0);
        rst = 1'b0;
        release_bus();
        rd(3'd3);
        rd(3'd4);

        for (int i = 0; i < 300; i++) begin
            off = 3'($urandom_range(0, 7));
            dat = (off == 3'd5) ? 32'($urandom_range(0, 4)) : $urandom();
            if (off == 3'd1 && $urandom_range(0, 3) == 0) dat = 32'hFFFF_FFFF;
            if ($urandom_range(0, 9) == 0) hold(off, $urandom_range(2, 5));
            else xfer(off, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), dat);
            idle($urandom_range(0, 2));
        end

        idle(4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
